// File: rtl/id_table_sequencer.sv
// id_table_sequencer: arbitrates one IDTable between the issue path (insert)
// and the response path (lookup, then invalidate on the last beat), tracks
// table occupancy and back-pressures issue while the table is full.
// Optional feature: define ID_SEQ_MISS_COUNTER_EN to build a saturating
// 16-bit lookup-miss counter on miss_count; otherwise miss_count is 0.
module id_table_sequencer #(
    parameter int unsigned NUMBER_OF_PORTS   = 2,
    parameter int unsigned ID_WIDTH          = 16,
    parameter int unsigned NUMBER_OF_ENTRIES = 32,
    localparam int unsigned ORIGIN_WIDTH = (NUMBER_OF_PORTS > 1) ? $clog2(NUMBER_OF_PORTS) : 1,
    localparam int unsigned OCC_WIDTH    = $clog2(NUMBER_OF_ENTRIES + 1)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [ID_WIDTH-1:0]     req_id,
    input  logic [ORIGIN_WIDTH-1:0] req_origin,
    input  logic                    rsp_valid,
    output logic                    rsp_ready,
    input  logic [ID_WIDTH-1:0]     rsp_id,
    input  logic                    rsp_last,
    output logic                    route_valid,
    input  logic                    route_ready,
    output logic [ORIGIN_WIDTH-1:0] route_origin,
    output logic                    route_miss,
    output logic [ID_WIDTH-1:0]     tbl_id,
    output logic [ORIGIN_WIDTH-1:0] tbl_origin,
    output logic                    tbl_insert,
    output logic                    tbl_lookup,
    output logic                    tbl_invalidate,
    input  logic [ORIGIN_WIDTH-1:0] tbl_answer,
    input  logic                    tbl_hit,
    output logic [OCC_WIDTH-1:0]    occupancy,
    output logic                    full,
    output logic [15:0]             miss_count
);

    localparam logic [OCC_WIDTH-1:0] OCC_MAX = OCC_WIDTH'(NUMBER_OF_ENTRIES);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        INSERT     = 3'd1,
        LOOKUP     = 3'd2,
        RESOLVE    = 3'd3,
        INVALIDATE = 3'd4,
        ROUTE      = 3'd5
    } state_t;

    typedef enum logic {
        PRIO_REQ = 1'b0,
        PRIO_RSP = 1'b1
    } prio_t;

    state_t                 state_q, state_d;
    prio_t                  prio_q, prio_d;
    logic                   grant_req, grant_rsp;
    logic                   req_elig, rsp_elig;
    logic                   insert_d, lookup_d, invalidate_d, route_valid_d;
    logic                   last_q;
    logic [OCC_WIDTH-1:0]   occ_d;

    // Candidates are masked during reset so the ready strobes read 0 immediately.
    assign req_elig  = req_valid && !full && !reset;
    assign rsp_elig  = rsp_valid && !reset;
    assign req_ready = grant_req;
    assign rsp_ready = grant_rsp;

    // State and priority pointer registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            prio_q  <= PRIO_RSP;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
        end
    end

    // Next-state, arbitration and next-cycle strobe decode.
    always_comb begin
        state_d       = state_q;
        prio_d        = prio_q;
        grant_req     = 1'b0;
        grant_rsp     = 1'b0;
        insert_d      = 1'b0;
        lookup_d      = 1'b0;
        invalidate_d  = 1'b0;
        route_valid_d = route_valid;
        case (state_q)
            IDLE: begin
                if (req_elig && rsp_elig) begin
                    if (prio_q == PRIO_RSP) begin
                        grant_rsp = 1'b1;
                        prio_d    = PRIO_REQ;
                    end else begin
                        grant_req = 1'b1;
                        prio_d    = PRIO_RSP;
                    end
                end else if (req_elig) begin
                    grant_req = 1'b1;
                end else if (rsp_elig) begin
                    grant_rsp = 1'b1;
                end
                if (grant_req) begin
                    state_d  = INSERT;
                    insert_d = 1'b1;
                end else if (grant_rsp) begin
                    state_d  = LOOKUP;
                    lookup_d = 1'b1;
                end
            end
            INSERT: begin
                state_d = IDLE;
            end
            LOOKUP: begin
                state_d = RESOLVE;
            end
            RESOLVE: begin
                if (tbl_hit && last_q) begin
                    state_d      = INVALIDATE;
                    invalidate_d = 1'b1;
                end else begin
                    state_d       = ROUTE;
                    route_valid_d = 1'b1;
                end
            end
            INVALIDATE: begin
                state_d       = ROUTE;
                route_valid_d = 1'b1;
            end
            ROUTE: begin
                if (route_ready) begin
                    state_d       = IDLE;
                    route_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Occupancy follows the strobe states, saturating at both ends.
    always_comb begin
        occ_d = occupancy;
        if (state_q == INSERT && occupancy != OCC_MAX) begin
            occ_d = occupancy + OCC_WIDTH'(1);
        end else if (state_q == INVALIDATE && occupancy != '0) begin
            occ_d = occupancy - OCC_WIDTH'(1);
        end
    end

    // Registered table strobes, table operands, routing result and occupancy.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tbl_insert     <= 1'b0;
            tbl_lookup     <= 1'b0;
            tbl_invalidate <= 1'b0;
            tbl_id         <= '0;
            tbl_origin     <= '0;
            last_q         <= 1'b0;
            route_valid    <= 1'b0;
            route_origin   <= '0;
            route_miss     <= 1'b0;
            occupancy      <= '0;
            full           <= 1'b0;
        end else begin
            tbl_insert     <= insert_d;
            tbl_lookup     <= lookup_d;
            tbl_invalidate <= invalidate_d;
            route_valid    <= route_valid_d;
            occupancy      <= occ_d;
            full           <= (occ_d == OCC_MAX);
            if (grant_req) begin
                tbl_id     <= req_id;
                tbl_origin <= req_origin;
            end
            if (grant_rsp) begin
                tbl_id <= rsp_id;
                last_q <= rsp_last;
            end
            if (state_q == RESOLVE) begin
                route_origin <= tbl_answer;
                route_miss   <= !tbl_hit;
            end
        end
    end

`ifdef ID_SEQ_MISS_COUNTER_EN
    // Saturating count of lookups that missed the table.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            miss_count <= 16'h0000;
        end else if (state_q == RESOLVE && !tbl_hit && miss_count != 16'hFFFF) begin
            miss_count <= miss_count + 16'd1;
        end
    end
`else
    assign miss_count = 16'h0000;
`endif

endmodule

// File: doc/id_table_sequencer.md
Name: id_table_sequencer

Overview:
- Controller that sequences and shares one IDTable instance between two requesters:
  - the forward issue path, which records the transaction ID and the origin port;
  - the response path, which looks up the ID to route the beat, then frees the entry on the last beat.
- Owns the table's insert/lookup/invalidate strobes.
- Tracks table occupancy and back-pressures issue when the table is full.
- Sits between the MemorEDF port demux and the slave response channel.

Parameters:
- NUMBER_OF_PORTS, 2: number of origin ports. ORIGIN_WIDTH = max(1, $clog2(NUMBER_OF_PORTS)).
- ID_WIDTH, 16: transaction ID width.
- NUMBER_OF_ENTRIES, 32: IDTable capacity. Occupancy counter width = $clog2(NUMBER_OF_ENTRIES+1).

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  issue request present.
- req_ready  out  1  issue request accepted this cycle.
- req_id  in  ID_WIDTH  ID to record.
- req_origin  in  ORIGIN_WIDTH  originating port.
- rsp_valid  in  1  response beat present.
- rsp_ready  out  1  response beat accepted this cycle.
- rsp_id  in  ID_WIDTH  response ID.
- rsp_last  in  1  final beat of the transaction.
- route_valid  out  1  routing result available.
- route_ready  in  1  consumer accepts the result.
- route_origin  out  ORIGIN_WIDTH  destination port.
- route_miss  out  1  ID was not found in the table.
- tbl_id  out  ID_WIDTH  to IDTable id.
- tbl_origin  out  ORIGIN_WIDTH  to IDTable origin.
- tbl_insert, tbl_lookup, tbl_invalidate  out  1 each  IDTable strobes.
- tbl_answer  in  ORIGIN_WIDTH  IDTable answer.
- tbl_hit  in  1  IDTable hit.
- occupancy  out  $clog2(NUMBER_OF_ENTRIES+1)  live entry count.
- full  out  1  occupancy == NUMBER_OF_ENTRIES.
- miss_count  out  16  see Optional Feature.

Behaviour:
- Reset (async, immediate):
  - FSM returns to IDLE.
  - All outputs are 0: req_ready, rsp_ready, route_*, tbl_* strobes, tbl_id, tbl_origin, occupancy, full, miss_count.
  - Priority pointer is set to RESPONSE.
  - Reset mid-operation abandons any in-flight lookup or route without invalidating.
- FSM states: IDLE, INSERT, LOOKUP, RESOLVE, INVALIDATE, ROUTE.
- IDLE arbitration:
  - Candidates are req (eligible only if !full) and rsp.
  - If both are eligible, the side named by the priority pointer wins, and the pointer toggles to the other side.
  - If only one is eligible, it wins and the pointer is unchanged.
  - req_ready or rsp_ready pulses for exactly one cycle in IDLE, combinationally with the grant. The winning id/origin/last are latched.
- INSERT (1 cycle):
  - tbl_insert=1; tbl_id and tbl_origin take the latched values.
  - occupancy += 1.
  - Next state: IDLE.
- LOOKUP (1 cycle): tbl_lookup=1, tbl_id takes the latched value. Next state: RESOLVE.
- RESOLVE:
  - Sample tbl_hit and tbl_answer, which are valid one cycle after tbl_lookup.
  - Store route_origin = tbl_answer and route_miss = !tbl_hit.
  - Next state is INVALIDATE if hit && last, otherwise ROUTE.
- INVALIDATE (1 cycle):
  - tbl_invalidate=1, tbl_id takes the latched value.
  - occupancy -= 1, saturating at 0.
  - Next state: ROUTE.
- ROUTE:
  - route_valid=1; route_origin and route_miss are held stable until route_ready.
  - On route_valid && route_ready, go to IDLE.
  - A miss never invalidates or decrements occupancy.
- Strobe rules:
  - At most one tbl_* strobe is high in any cycle.
  - tbl_id is held when no strobe is high.
- Latency, no stall:
  - insert: grant to strobe is 1 cycle.
  - response: grant to route_valid is 3 cycles (non-last) or 4 cycles (last+hit).
- Full:
  - req_ready is never asserted while full; responses remain serviceable.
  - full deasserts the cycle after the INVALIDATE that takes occupancy below NUMBER_OF_ENTRIES.
- Empty: a response with occupancy 0 is still looked up. It yields route_miss=1 and occupancy stays 0.
- The block issues no duplicate-ID check on insert; duplicates count as separate entries.

Optional Feature:
- Macro: ID_SEQ_MISS_COUNTER_EN.
- Defined:
  - miss_count is a 16-bit counter incremented in RESOLVE when !tbl_hit.
  - It saturates at 16'hFFFF and is cleared by reset.
- Undefined: miss_count is tied to 16'h0000 and no counter logic is synthesised.

Test Plan:
- Reset, then insert id 0x018d, 0x01ad, 0x01cd, 0x01ed with origin 1 -> four tbl_insert pulses one cycle after each grant; occupancy reaches 4.
- Non-last response, id 0x01ad -> tbl_lookup pulse, route_valid 3 cycles after grant with route_origin=1, route_miss=0; no tbl_invalidate; occupancy stays 4.
- Last response, id 0x01ed -> tbl_invalidate with tbl_id 0x01ed; occupancy 3; a repeat lookup of 0x01ed returns route_miss=1 and, if ID_SEQ_MISS_COUNTER_EN is defined, miss_count=1.
- Fill to 32 entries -> full=1 and req_ready stays 0 with req_valid held; one last+hit response -> occupancy 31, full=0, and the pending request is granted next IDLE.
- req_valid and rsp_valid held together from IDLE -> grants alternate rsp, req, rsp, req.
- Hold route_ready=0 for 5 cycles -> route_origin and route_miss stay stable and no new grant is issued.
- Assert reset mid-RESOLVE -> all outputs 0 immediately and occupancy 0.
